// File: rtl/timer_bank.sv
// timer_bank: a bank of independent up-counting timer channels.
// Each channel keeps a shadow (period, mode) pair written by the config port.
// It also keeps an active pair that is used for counting. The active pair is
// loaded from the shadow pair on start, on retrigger and on every periodic wrap.
// Because of this, a config write never disturbs a count that is in progress.
module timer_bank #(
  parameter int NCH            = 4,
  parameter int WIDTH          = 16,
  parameter int DEFAULT_PERIOD = 1000,
  localparam int CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_we,
  input  logic [CHW-1:0]       i_cfg_ch,
  input  logic [WIDTH-1:0]     i_cfg_period,
  input  logic                 i_cfg_oneshot,
  input  logic [NCH-1:0]       i_start,
  input  logic [NCH-1:0]       i_stop,
  input  logic [NCH-1:0]       i_clr,
  output logic [NCH-1:0]       o_tick,
  output logic [NCH-1:0]       o_flag,
  output logic [NCH-1:0]       o_busy,
  output logic [NCH*WIDTH-1:0] o_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_PERIOD);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t           state;
    logic [WIDTH-1:0] shadow_period;
    logic             shadow_oneshot;
    logic [WIDTH-1:0] active_period;
    logic             active_oneshot;
    logic [WIDTH-1:0] count;
    logic             tick_q;
    logic             flag_q;

    logic             cfg_hit;
    logic [WIDTH-1:0] next_shadow_period;
    logic             next_shadow_oneshot;
    logic [WIDTH-1:0] eff_period;
    logic             terminal;
    logic             tick_next;

    // Decode the config write for this channel, the write-through shadow value, and the terminal-count condition
    always_comb begin
      cfg_hit             = i_cfg_we && (i_cfg_ch == CHW'(c));
      next_shadow_period  = cfg_hit ? i_cfg_period  : shadow_period;
      next_shadow_oneshot = cfg_hit ? i_cfg_oneshot : shadow_oneshot;
      eff_period          = (active_period == '0) ? WIDTH'(1) : active_period;
      terminal            = (state == RUN) && (count == (eff_period - WIDTH'(1)));
      tick_next           = terminal && !i_stop[c] && !i_start[c];
    end

    // Channel state machine: stop beats start, start beats the terminal tick, and reset beats everything
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state          <= IDLE;
        shadow_period  <= RESET_PERIOD;
        shadow_oneshot <= 1'b0;
        active_period  <= RESET_PERIOD;
        active_oneshot <= 1'b0;
        count          <= '0;
        tick_q         <= 1'b0;
        flag_q         <= 1'b0;
      end else begin
        shadow_period  <= next_shadow_period;
        shadow_oneshot <= next_shadow_oneshot;
        tick_q         <= tick_next;
        flag_q         <= tick_next | (flag_q & ~i_clr[c]);
        if (i_stop[c]) begin
          state <= IDLE;
          count <= '0;
        end else if (i_start[c]) begin
          state          <= RUN;
          count          <= '0;
          active_period  <= next_shadow_period;
          active_oneshot <= next_shadow_oneshot;
        end else if (state == RUN) begin
          if (terminal) begin
            count <= '0;
            if (active_oneshot) begin
              state <= IDLE;
            end else begin
              active_period  <= next_shadow_period;
              active_oneshot <= next_shadow_oneshot;
            end
          end else begin
            count <= count + WIDTH'(1);
          end
        end
      end
    end

    assign o_tick[c]                  = tick_q;
    assign o_flag[c]                  = flag_q;
    assign o_busy[c]                  = (state == RUN);
    assign o_count[c*WIDTH +: WIDTH]  = count;
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed test of timer_bank with its default parameters (4 channels, 16 bits, period 1000).
// Inputs change 1 time unit after a rising edge, and outputs are checked at that same point.
module tb_timer_bank;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic        cfg_oneshot;
  logic [3:0]  start;
  logic [3:0]  stop;
  logic [3:0]  clr;
  logic [3:0]  tick;
  logic [3:0]  flag;
  logic [3:0]  busy;
  logic [63:0] count;

  int total_checks;
  int bad_checks;

  timer_bank #(
    .NCH(4),
    .WIDTH(16),
    .DEFAULT_PERIOD(1000)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_cfg_we(cfg_we),
    .i_cfg_ch(cfg_ch),
    .i_cfg_period(cfg_period),
    .i_cfg_oneshot(cfg_oneshot),
    .i_start(start),
    .i_stop(stop),
    .i_clr(clr),
    .o_tick(tick),
    .o_flag(flag),
    .o_busy(busy),
    .o_count(count)
  );

  // Free-running clock with a period of 10 time units
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] ch, input logic [15:0] per, input logic os,
                               input logic [3:0] st, input logic [3:0] sp, input logic [3:0] cl);
    cfg_we      = we;
    cfg_ch      = ch;
    cfg_period  = per;
    cfg_oneshot = os;
    start       = st;
    stop        = sp;
    clr         = cl;
    @(posedge clk);
    #1;
    cfg_we      = 1'b0;
    cfg_ch      = 2'd0;
    cfg_period  = 16'd0;
    cfg_oneshot = 1'b0;
    start       = 4'b0;
    stop        = 4'b0;
    clr         = 4'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0, 4'b0, 4'b0);
  endtask

  // Directed scenario sequence
  initial begin
    total_checks = 0;
    bad_checks   = 0;
    rst          = 1'b1;
    cfg_we       = 1'b0;
    cfg_ch       = 2'd0;
    cfg_period   = 16'd0;
    cfg_oneshot  = 1'b0;
    start        = 4'b0;
    stop         = 4'b0;
    clr          = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tick", 64'(tick), 64'd0);
    checkOutput("rst_flag", 64'(flag), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_count", count, 64'd0);
    rst = 1'b0;

    // Periodic period 5 on ch0
    applyStimulus(1'b1, 2'd0, 16'd5, 1'b0, 4'b0, 4'b0, 4'b0);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0001, 4'b0, 4'b0);
    checkOutput("p5_first_count", 64'(count[15:0]), 64'd0);
    checkOutput("p5_first_busy", 64'(busy[0]), 64'd1);
    checkOutput("p5_first_tick", 64'(tick[0]), 64'd0);
    for (int k = 1; k <= 15; k++) begin
      idleCycles(1);
      checkOutput("p5_count", 64'(count[15:0]), 64'(k % 5));
      checkOutput("p5_tick", 64'(tick[0]), 64'((k % 5) == 0));
    end
    checkOutput("p5_flag", 64'(flag[0]), 64'd1);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0, 4'b0001, 4'b0);
    checkOutput("p5_stop_busy", 64'(busy[0]), 64'd0);
    checkOutput("p5_stop_count", 64'(count[15:0]), 64'd0);

    // One-shot period 3 on ch1
    applyStimulus(1'b1, 2'd1, 16'd3, 1'b1, 4'b0, 4'b0, 4'b0);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0010, 4'b0, 4'b0);
    for (int k = 1; k <= 8; k++) begin
      idleCycles(1);
      checkOutput("os_tick", 64'(tick[1]), 64'(k == 3));
      checkOutput("os_busy", 64'(busy[1]), 64'(k < 3));
      checkOutput("os_count", 64'(count[31:16]), (k < 3) ? 64'(k) : 64'd0);
    end

    // Config write in the same cycle as start is used by that start (ch2, period 2)
    applyStimulus(1'b1, 2'd2, 16'd2, 1'b0, 4'b0100, 4'b0, 4'b0);
    for (int k = 1; k <= 4; k++) begin
      idleCycles(1);
      checkOutput("wt_tick", 64'(tick[2]), 64'((k % 2) == 0));
    end

    // Shadow write mid-count: next tick still at +5, then every 2
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0001, 4'b0, 4'b0);
    idleCycles(1);
    checkOutput("sh_count1", 64'(count[15:0]), 64'd1);
    applyStimulus(1'b1, 2'd0, 16'd2, 1'b0, 4'b0, 4'b0, 4'b0);
    checkOutput("sh_count2", 64'(count[15:0]), 64'd2);
    for (int k = 3; k <= 9; k++) begin
      idleCycles(1);
      checkOutput("sh_tick", 64'(tick[0]), 64'((k == 5) || (k == 7) || (k == 9)));
    end
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0, 4'b0001, 4'b0);

    // Periods 0 and 1 tick every cycle; start+stop together keeps a channel idle
    applyStimulus(1'b1, 2'd3, 16'd0, 1'b0, 4'b0, 4'b0, 4'b0);
    applyStimulus(1'b1, 2'd2, 16'd1, 1'b0, 4'b0, 4'b0100, 4'b0);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b1100, 4'b0, 4'b0);
    checkOutput("p01_first_tick", 64'(tick[3:2]), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      idleCycles(1);
      checkOutput("p01_tick", 64'(tick[3:2]), 64'd3);
      checkOutput("p01_count", count[63:32], 64'd0);
    end
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0, 4'b1100, 4'b0);
    checkOutput("p01_all_idle", 64'(busy), 64'd0);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0010, 4'b0010, 4'b0);
    checkOutput("ss_busy", 64'(busy[1]), 64'd0);
    checkOutput("ss_count", 64'(count[31:16]), 64'd0);
    idleCycles(2);
    checkOutput("ss_tick", 64'(tick[1]), 64'd0);

    // Flag set beats clear; clear alone clears; retrigger suppresses the tick
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0, 4'b0, 4'b1111);
    checkOutput("fl_cleared", 64'(flag), 64'd0);
    applyStimulus(1'b1, 2'd0, 16'd5, 1'b0, 4'b0, 4'b0, 4'b0);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0001, 4'b0, 4'b0);
    idleCycles(4);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0, 4'b0, 4'b0001);
    checkOutput("fl_tick", 64'(tick[0]), 64'd1);
    checkOutput("fl_set_wins", 64'(flag[0]), 64'd1);
    idleCycles(1);
    checkOutput("fl_hold", 64'(flag[0]), 64'd1);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0, 4'b0, 4'b0001);
    checkOutput("fl_clear", 64'(flag[0]), 64'd0);
    idleCycles(2);
    checkOutput("rt_count4", 64'(count[15:0]), 64'd4);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0001, 4'b0, 4'b0);
    checkOutput("rt_no_tick", 64'(tick[0]), 64'd0);
    checkOutput("rt_count0", 64'(count[15:0]), 64'd0);
    for (int j = 1; j <= 5; j++) begin
      idleCycles(1);
      checkOutput("rt_tick", 64'(tick[0]), 64'(j == 5));
    end

    // Reset mid-count clears everything and restores the default period and periodic mode
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b1111, 4'b0, 4'b0);
    idleCycles(2);
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b1111, 4'b0, 4'b0);
    rst = 1'b0;
    checkOutput("mr_tick", 64'(tick), 64'd0);
    checkOutput("mr_flag", 64'(flag), 64'd0);
    checkOutput("mr_busy", 64'(busy), 64'd0);
    checkOutput("mr_count", count, 64'd0);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 4'b0011, 4'b0, 4'b0);
    idleCycles(999);
    checkOutput("dp_count999", 64'(count[15:0]), 64'd999);
    checkOutput("dp_pre_tick", 64'(tick[1:0]), 64'd0);
    idleCycles(1);
    checkOutput("dp_tick", 64'(tick[1:0]), 64'd3);
    checkOutput("dp_wrap", 64'(count[31:0]), 64'd0);
    checkOutput("dp_periodic", 64'(busy[1:0]), 64'd3);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent timer channels, legal 1..16.
REQ-002 Parameter WIDTH, default 16: counter/period width in bits, legal 2..32.
REQ-003 Parameter DEFAULT_PERIOD, default 1000: period loaded into every channel at reset, must fit in WIDTH bits.
REQ-004 Clock and reset: i_clk is the clock; i_rst is reset, synchronous, active-high.
REQ-005 i_cfg_we  in  1  config write strobe.
REQ-006 i_cfg_ch  in  max(1,$clog2(NCH))  channel index for the write; writes to an index >= NCH are ignored.
REQ-007 i_cfg_period  in  WIDTH  period value for the write.
REQ-008 i_cfg_oneshot  in  1  mode for the write: 1 = one-shot, 0 = periodic.
REQ-009 i_start  in  NCH  per-channel start/retrigger pulse.
REQ-010 i_stop  in  NCH  per-channel stop pulse.
REQ-011 i_clr  in  NCH  per-channel sticky-flag clear.
REQ-012 o_tick  out  NCH  per-channel one-cycle terminal-count pulse, registered.
REQ-013 o_flag  out  NCH  per-channel sticky tick flag.
REQ-014 o_busy  out  NCH  per-channel running indicator.
REQ-015 o_count  out  NCH*WIDTH  channel c count at bits [c*WIDTH +: WIDTH].

Function
REQ-016 Each channel SHALL hold shadow registers (period, mode) written by config, and active registers (period, mode) used for counting.
REQ-017 A config write SHALL update only the shadow registers of i_cfg_ch; it SHALL NOT alter a running count.
REQ-018 Active registers SHALL load from the shadows on start (from IDLE or as a retrigger) and on every periodic wrap.
REQ-019 Effective period SHALL be max(active period, 1); period 0 behaves as period 1.
REQ-020 Each channel SHALL have two states: IDLE (o_busy=0, count held) and RUN (o_busy=1).
REQ-021 IDLE -> RUN on i_start; the count SHALL be 0 in the first RUN cycle.
REQ-022 In RUN, the count SHALL increment by 1 per cycle while it is below effective period - 1.
REQ-023 In RUN with count == effective period - 1, the next cycle SHALL have o_tick=1 and count=0.
REQ-024 After that tick, periodic mode SHALL stay in RUN; one-shot mode SHALL go to IDLE with count 0.
REQ-025 Tick spacing SHALL be exactly effective period cycles; the first tick comes effective period cycles after the start cycle.
REQ-026 i_start in RUN SHALL restart the count at 0 and reload the active registers; a terminal tick due in that same cycle SHALL be suppressed.
REQ-027 i_stop SHALL force IDLE with count 0 and no tick.
REQ-028 When i_stop and i_start coincide, stop SHALL win.
REQ-029 A config write coinciding with i_start on the same channel SHALL be used by that start (shadow write-through).
REQ-030 o_flag SHALL set on the cycle o_tick is asserted and clear on i_clr; when both coincide, set SHALL win.
REQ-031 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-032 All outputs SHALL be registered; the counter SHALL wrap only via REQ-023 and never overflow WIDTH.

Reset
REQ-033 On i_rst, every channel SHALL go to IDLE, with count=0, o_tick=0, o_flag=0, o_busy=0.
REQ-034 On i_rst, shadow and active periods SHALL equal DEFAULT_PERIOD[WIDTH-1:0], with mode periodic.
REQ-035 i_rst SHALL override all other inputs in the same cycle, including mid-count.

Verification
REQ-036 Write period 5 periodic to ch0, pulse start -> o_tick[0] asserted 5, 10, 15 cycles after the start; o_count[0] runs 0,1,2,3,4,0.
REQ-037 Write period 3 one-shot to ch1, start -> single tick at +3 cycles, then o_busy[1]=0 and count 0; no further ticks.
REQ-038 Ch0 running period 5; write period 2 at count 1 -> next tick still at +5, following ticks every 2 cycles.
REQ-039 Periods 0 and 1 periodic -> tick every cycle; assert start+stop together -> channel stays IDLE.
REQ-040 Tick coinciding with i_clr -> o_flag=1; a later i_clr alone -> o_flag=0; retrigger at count 4 of period 5 -> no tick that cycle, next tick 5 cycles later.
REQ-041 Assert i_rst with all channels mid-count -> next cycle all outputs 0, and periods read back as DEFAULT_PERIOD after start.
